// File: rtl/axis_switch_pkg.sv
// -----------------------------------------------------------------------------
// axis_switch_pkg
// Shared definitions for the AXI Stream switch ingress demux.
//   state_t        : demux FSM state encoding (ST_IDLE, ST_FWD, ST_DROP)
//   DROP_CNT_WIDTH : width of the saturating dropped-packet counter
// -----------------------------------------------------------------------------
package axis_switch_pkg;

    localparam int DROP_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // waiting for the first beat of a packet
        ST_FWD  = 2'd1,  // forwarding the body of an in-range packet
        ST_DROP = 2'd2   // swallowing the body of an out-of-range packet
    } state_t;

endpackage

// File: rtl/axis_demux_out_reg.sv
// -----------------------------------------------------------------------------
// axis_demux_out_reg
// One-deep registered output stage of the ingress demux. Holds a single beat
// tagged with its destination port, decodes the per-port valid vector and
// selects the ready of the port that currently owns the register.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   load_i            : capture load_{dest,data,last}_i on this edge
//   load_dest_i       : destination port of the beat being loaded
//   load_data_i       : beat data
//   load_last_i       : beat is the last of its packet
//   out_vld_o         : register holds a beat
//   out_ready_o       : ready of the port the held beat is addressed to
//   m_dest_o          : held destination (shared by all ports)
//   m_data_o          : held data (shared by all ports)
//   m_last_o          : held last flag (shared by all ports)
//   m_valid_o         : per-port valid, one-hot or zero
//   m_ready_i         : per-port ready
// -----------------------------------------------------------------------------
module axis_demux_out_reg #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DEST_WIDTH = 8,
    parameter int N_PORTS      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic [T_DEST_WIDTH-1:0] load_dest_i,
    input  logic [T_DATA_WIDTH-1:0] load_data_i,
    input  logic                    load_last_i,
    output logic                    out_vld_o,
    output logic                    out_ready_o,
    output logic [T_DEST_WIDTH-1:0] m_dest_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic [N_PORTS-1:0]      m_valid_o,
    input  logic [N_PORTS-1:0]      m_ready_i
);

    logic                    out_vld_q;
    logic [T_DEST_WIDTH-1:0] dest_q;
    logic [T_DATA_WIDTH-1:0] data_q;
    logic                    last_q;
    logic [N_PORTS-1:0]      valid_vec;

    // Decode the held destination into a per-port valid. Only in-range
    // destinations are ever loaded, so exactly one bit is set while valid.
    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            valid_vec[i] = out_vld_q & (dest_q == T_DEST_WIDTH'(i));
        end
    end

    // Masking ready with valid means only the owning port can drain the
    // register; ready on any other port has no effect.
    assign out_ready_o = |(valid_vec & m_ready_i);

    // A load on the same edge as the output handshake simply overwrites the
    // register, so there is no bubble between back-to-back beats. While
    // stalled (valid, owner not ready) nothing changes, keeping m_* stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            dest_q    <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
        end else if (load_i) begin
            out_vld_q <= 1'b1;
            dest_q    <= load_dest_i;
            data_q    <= load_data_i;
            last_q    <= load_last_i;
        end else if (out_ready_o) begin
            out_vld_q <= 1'b0;
        end
    end

    assign out_vld_o = out_vld_q;
    assign m_dest_o  = dest_q;
    assign m_data_o  = data_q;
    assign m_last_o  = last_q;
    assign m_valid_o = valid_vec;

endmodule

// File: rtl/axis_switch_demux.sv
// -----------------------------------------------------------------------------
// axis_switch_demux
// Ingress routing stage of the AXI Stream switch. Steers each whole packet of
// the single input stream to the output port named by its first-beat dest,
// through a one-deep registered output stage. Packets with dest >= N_PORTS
// are consumed and discarded.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; a source holds valid and its payload stable until that edge, and
// ready may be high while valid is low. On the output side each port i uses
// m_valid[i]/m_ready[i] with the shared m_dest/m_data/m_last payload.
//
// Optional feature (macro AXIS_DEMUX_DROP_CNT_EN): adds the drop_cnt output,
// a 16-bit saturating count of out-of-range packets. Without the macro the
// port and counter are absent and dropping is otherwise identical.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   s_dest     : destination port, sampled on the first beat of a packet
//   s_data     : input beat data
//   s_last     : last beat of the input packet
//   s_valid    : input beat valid
//   s_ready    : input beat accepted
//   m_dest     : destination of the held output beat (shared)
//   m_data     : output data (shared)
//   m_last     : output last (shared)
//   m_valid    : per-port valid, one-hot or zero
//   m_ready    : per-port ready
//   dbg_state  : current FSM state, for observation only
//   drop_cnt   : dropped-packet count (only with AXIS_DEMUX_DROP_CNT_EN)
// -----------------------------------------------------------------------------
module axis_switch_demux
    import axis_switch_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DEST_WIDTH = 8,
    parameter int N_PORTS      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [T_DEST_WIDTH-1:0]   s_dest,
    input  logic [T_DATA_WIDTH-1:0]   s_data,
    input  logic                      s_last,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [T_DEST_WIDTH-1:0]   m_dest,
    output logic [T_DATA_WIDTH-1:0]   m_data,
    output logic                      m_last,
    output logic [N_PORTS-1:0]        m_valid,
    input  logic [N_PORTS-1:0]        m_ready,
    output state_t                    dbg_state
`ifdef AXIS_DEMUX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);

    // One extra bit so N_PORTS == 2**T_DEST_WIDTH is representable.
    localparam logic [T_DEST_WIDTH:0] DEST_LIMIT = (T_DEST_WIDTH + 1)'(N_PORTS);

    state_t                  state_q;
    logic [T_DEST_WIDTH-1:0] dest_q;

    logic                    out_vld;
    logic                    out_ready;
    logic                    in_range;
    logic                    s_hs;
    logic                    load;
    logic [T_DEST_WIDTH-1:0] load_dest;

    assign in_range = ({1'b0, s_dest} < DEST_LIMIT);

    // In IDLE/FWD a beat is taken when the register is empty or draining this
    // edge. Because out_ready is the ready of the port owning the register,
    // a first beat to a new port waits until the previous packet's final beat
    // has actually left. DROP never touches the register, so it never stalls.
    assign s_ready = (state_q == ST_DROP) | ~out_vld | out_ready;
    assign s_hs    = s_valid & s_ready;

    // First beats carry their own dest; body beats reuse the locked one so a
    // changing s_dest mid-packet cannot split the packet across ports.
    assign load      = s_hs & ((state_q == ST_FWD) | ((state_q == ST_IDLE) & in_range));
    assign load_dest = (state_q == ST_IDLE) ? s_dest : dest_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dest_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_hs) begin
                        dest_q <= s_dest;
                        if (s_last) begin
                            state_q <= ST_IDLE;
                        end else if (in_range) begin
                            state_q <= ST_FWD;
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (s_hs && s_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state_q;

`ifdef AXIS_DEMUX_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_d;

    // Counted once per packet on its first beat; holds at all-ones.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if ((state_q == ST_IDLE) && s_hs && !in_range && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    axis_demux_out_reg #(
        .T_DATA_WIDTH (T_DATA_WIDTH),
        .T_DEST_WIDTH (T_DEST_WIDTH),
        .N_PORTS      (N_PORTS)
    ) u_out_reg (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .load_dest_i (load_dest),
        .load_data_i (s_data),
        .load_last_i (s_last),
        .out_vld_o   (out_vld),
        .out_ready_o (out_ready),
        .m_dest_o    (m_dest),
        .m_data_o    (m_data),
        .m_last_o    (m_last),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready)
    );

endmodule

// File: tb/tb_axis_switch_demux.sv
// -----------------------------------------------------------------------------
// tb_axis_switch_demux
// Self-checking bench for axis_switch_demux (default parameters). The driver
// pushes the expected output beat for every accepted in-range beat; a monitor
// pops and compares whenever a port handshakes, and checks that stalled
// outputs stay stable and that m_valid matches m_dest.
// Works with or without AXIS_DEMUX_DROP_CNT_EN.
// -----------------------------------------------------------------------------
module tb_axis_switch_demux;
    import axis_switch_pkg::*;

    localparam int DW = 8;
    localparam int DEW = 8;
    localparam int NP = 4;
    localparam int EW = DEW + DW + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [DEW-1:0] s_dest = '0;
    logic [DW-1:0]  s_data = '0;
    logic           s_last = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [DEW-1:0] m_dest;
    logic [DW-1:0]  m_data;
    logic           m_last;
    logic [NP-1:0]  m_valid;
    logic [NP-1:0]  m_ready = '1;
    state_t         dbg_state;
`ifdef AXIS_DEMUX_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;
`endif

    int             n_cmp = 0;
    int             n_err = 0;
    logic [EW-1:0]  exp_q[$];
    int             exp_drop = 0;
    bit             rand_ready = 1'b0;

    axis_switch_demux #(
        .T_DATA_WIDTH (DW),
        .T_DEST_WIDTH (DEW),
        .N_PORTS      (NP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_dest    (s_dest),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_dest    (m_dest),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
`ifdef AXIS_DEMUX_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Random ready: each bit high with probability 3/4.
    always @(posedge clk) begin
        #1;
        if (rand_ready) m_ready = NP'($urandom) | NP'($urandom);
    end

    // ---------------- driver ----------------
    // Presents one beat and waits for acceptance. pkt_dest is the packet's
    // first-beat dest, which decides where every beat of the packet goes.
    task automatic send_beat(input logic [DEW-1:0] d, input logic [DW-1:0] data,
                             input logic last, input logic [DEW-1:0] pkt_dest,
                             output int waits);
        bit done;
        done = 1'b0;
        waits = 0;
        s_valid = 1'b1;
        s_dest = d;
        s_data = data;
        s_last = last;
        while (!done) begin
            @(negedge clk);
            if (s_ready) begin
                done = 1'b1;
                if (int'(pkt_dest) < NP) exp_q.push_back({pkt_dest, data, last});
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
            if (!done && waits > 300) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: got no s_ready expected accept within 300 cycles");
                done = 1'b1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic send_packet(input logic [DEW-1:0] dest, input int len,
                               input int gap_max, input bit full_rate);
        int w;
        int g;
        logic [DEW-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = (b == 0) ? dest : DEW'($urandom);
            send_beat(d, DW'($urandom), (b == len - 1), dest, w);
            if (b == 0 && int'(dest) >= NP) exp_drop++;
            if (full_rate) check("full_rate_accept", w, 0);
            else if (b > 0 && int'(dest) >= NP) check("drop_s_ready", w, 0);
            g = $urandom_range(0, gap_max);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit             hold_pend = 1'b0;
    logic [NP+EW-1:0] hold_val;
    logic [NP-1:0]  oh;
    logic [EW-1:0]  e;

    always @(negedge clk) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) check("stall_hold", {m_valid, m_dest, m_data, m_last}, hold_val);
            if (m_valid != '0) begin
                oh = (int'(m_dest) < NP) ? (NP'(1) << m_dest) : '0;
                check("valid_onehot", m_valid, oh);
                if ((m_valid & m_ready) != '0) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got %0h expected no output", {m_dest, m_data, m_last});
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {m_dest, m_data, m_last}, e);
                    end
                end
            end
            hold_pend = (m_valid != '0) && ((m_valid & m_ready) == '0);
            hold_val = {m_valid, m_dest, m_data, m_last};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int cyc;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_payload", {m_dest, m_data, m_last}, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_state", dbg_state, ST_IDLE);
`ifdef AXIS_DEMUX_DROP_CNT_EN
        check("rst_drop_cnt", drop_cnt, 0);
`endif
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single-beat packet, 1-cycle latency.
        send_beat(8'd2, 8'hA5, 1'b1, 8'd2, w);
        check("single_no_wait", w, 0);
        @(negedge clk);
        check("single_valid", m_valid, 4'b0100);
        check("single_data", m_data, 8'hA5);
        check("single_s_ready", s_ready, 1);
        @(negedge clk);
        check("single_gone", m_valid, 0);
        @(posedge clk);
        #1;

        // 4-beat packet with s_dest changing after the first beat.
        send_beat(8'd1, 8'h11, 1'b0, 8'd1, w);
        send_beat(8'd3, 8'h22, 1'b0, 8'd1, w);
        send_beat(8'd3, 8'h33, 1'b0, 8'd1, w);
        send_beat(8'd3, 8'h44, 1'b1, 8'd1, w);

        // Backpressure on port 0 mid-packet for 5 cycles.
        fork
            send_packet(8'd0, 8, 0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #2 m_ready = 4'b1110;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_s_ready", s_ready, 0);
                end
                @(posedge clk);
                #2 m_ready = 4'b1111;
            end
        join
        send_packet(8'd0, 4, 0, 1'b1);

        // Out-of-range packet followed by a normal one.
        repeat (3) @(posedge clk);
        #1;
        send_packet(8'd7, 3, 0, 1'b1);
        @(negedge clk);
        check("drop_no_valid", m_valid, 0);
`ifdef AXIS_DEMUX_DROP_CNT_EN
        check("drop_cnt_one", drop_cnt, 1);
`endif
        @(posedge clk);
        #1;
        send_packet(8'd0, 3, 0, 1'b0);

        // Reset during beat 2 of a packet to port 2.
        send_beat(8'd2, 8'h61, 1'b0, 8'd2, w);
        send_beat(8'd2, 8'h62, 1'b0, 8'd2, w);
        s_valid = 1'b1;
        s_dest = 8'd2;
        s_data = 8'h63;
        s_last = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        exp_drop = 0;
        #1;
        check("midrst_m_valid", m_valid, 0);
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        send_beat(8'd3, 8'h5C, 1'b1, 8'd3, w);
        @(negedge clk);
        check("postrst_port3", m_valid, 4'b1000);
        @(posedge clk);
        #1;

        // Back-to-back packets to ports 0 then 1 with port 0 stalled.
        m_ready = 4'b1110;
        fork
            begin
                send_packet(8'd0, 2, 0, 1'b0);
                send_packet(8'd1, 2, 0, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                check("b2b_port1_waits", m_valid, 4'b0001);
                m_ready = 4'b1111;
            end
        join

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            send_packet(DEW'($urandom_range(0, 5)), $urandom_range(1, 5), 2, 1'b0);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 m_ready = '1;

        // Drain, bounded.
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        check("final_idle_valid", m_valid, 0);
`ifdef AXIS_DEMUX_DROP_CNT_EN
        check("final_drop_cnt", drop_cnt, exp_drop);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_switch_demux.md
# axis_switch_demux

Ingress routing stage of the AXI Stream switch, directly upstream of the per-output-port mux. It accepts one input stream with `dest` and steers each whole packet to the output port indexed by the first-beat `dest`, through a one-deep registered output stage. Packets whose `dest` is out of range are consumed and discarded. Each output port feeds one slave input of a downstream mux.

## Interface
- `T_DATA_WIDTH`, default 8: data width.
- `T_DEST_WIDTH`, default 8: dest width.
- `N_PORTS`, default 4: number of output ports, range 2..2**T_DEST_WIDTH. Valid dest range is 0..N_PORTS-1.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_dest`  in  T_DEST_WIDTH  destination port of the packet.
- `s_data`  in  T_DATA_WIDTH  beat data.
- `s_last`  in  1  last beat of the packet.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted.
- `m_dest`  out  T_DEST_WIDTH  locked dest. Shared by all ports.
- `m_data`  out  T_DATA_WIDTH  shared output data.
- `m_last`  out  1  shared output last.
- `m_valid`  out  N_PORTS  per-port valid; at most one bit set (one-hot or zero).
- `m_ready`  in  N_PORTS  per-port ready.
- `drop_cnt`  out  16  count of dropped packets. Present only with `AXIS_DEMUX_DROP_CNT_EN`.

## Operation
- FSM states: IDLE, FWD, DROP.
- **IDLE**, on handshake `s_valid & s_ready`:
  - sample `s_dest` into `dest_q`.
  - If `s_dest < N_PORTS`, load the beat into the output register. Next state is FWD, or IDLE if `s_last`.
  - Otherwise discard the beat. Next state is DROP, or IDLE if `s_last`.
- **FWD**: every accepted beat loads the output register, tagged with `dest_q`. `s_dest` of non-first beats is ignored. An accepted beat with `s_last` returns the FSM to IDLE.
- **DROP**: `s_ready` = 1. Beats are discarded. An accepted beat with `s_last` returns the FSM to IDLE.
- **Output register**: `out_vld`, `m_dest`, `m_data`, `m_last`.
  - `m_valid[i]` = `out_vld & (m_dest == i)`.
  - Accepted when `m_ready[m_dest]` is high.
- **s_ready** in IDLE/FWD = `~out_vld | m_ready[m_dest]`. This gives full throughput: 1 beat/cycle with ready held high.
- Packets never interleave. Beat order is preserved.

## Timing
- **Reset values**: FSM = IDLE, `out_vld` = 0, `m_valid` = 0, `m_dest`/`m_data`/`m_last` = 0, `drop_cnt` = 0. `s_ready` = 1 after reset.
- **Latency**: a beat accepted at edge k is presented on `m_*` from edge k (visible in cycle k+1). Input-to-output latency is 1 cycle.
- **Outputs hold while stalled**: while `m_valid[i] & ~m_ready[i]`, `m_valid`, `m_dest`, `m_data` and `m_last` are held stable. This is required by the downstream mux checker.
- **Simultaneous events**: on the same edge as the output handshake, a new accepted beat replaces the register contents. No bubble is inserted.
- **Packet back-to-back**: last beat and next packet's first beat may be accepted in consecutive cycles. The new first beat is sampled in IDLE on the cycle after `last`.
- **Route change while stalled**: a new packet to a different port waits in IDLE until the previous packet's final beat leaves the output register. A port's ready never releases another port's data.
- **Reset mid-packet**: the partial packet is abandoned and the register cleared. The next input beat is treated as a first beat.
- **Ready behaviour**: `m_ready` on non-selected ports has no effect. `s_ready` may be high while `s_valid` is low.

## Configuration
- `AXIS_DEMUX_DROP_CNT_EN` defined:
  - `drop_cnt` port exists.
  - Increments by 1 on the first-beat handshake of each out-of-range packet.
  - Saturates at 16'hFFFF.
- Not defined: the port and counter are absent. Drop behaviour is otherwise identical.

## Structure
- **Package `axis_switch_pkg`**: FSM state enum (`ST_IDLE`, `ST_FWD`, `ST_DROP`) and the `DROP_CNT_WIDTH` = 16 constant.
- **Sub-module `axis_demux_out_reg`**: the output register plus the per-port valid decode and `m_ready` select. The FSM, dest lock and drop counter remain in the top.

## Test plan
- **Single-beat packet**: dest=2, data=8'hA5, last=1, all ready=1 → `m_valid`=4'b0100 for 1 cycle with data A5, `s_ready` stays 1.
- **4-beat packet with dest change**: dest=1 on beat 0, `s_dest` changed to 3 on beats 1–3 → all 4 beats on port 1 with `m_dest`=1, port 3 idle.
- **Backpressure**: `m_ready[0]`=0 for 5 cycles mid-packet → `m_*` held stable, `s_ready`=0, no beat lost or duplicated. Throughput returns to 1 beat/cycle after release.
- **Out-of-range dest**: dest=7 with N_PORTS=4, 3-beat packet → `s_ready`=1 throughout, `m_valid`=0, `drop_cnt` 0→1. The following packet to dest 0 is delivered intact.
- **Reset mid-packet**: `reset` asserted during beat 2 of a packet to port 2 → `m_valid`=0 immediately. The next beat with dest=3 is routed to port 3.
- **Back-to-back packets**: dest 0 then dest 1, with `m_ready[0]` stalled → the second packet appears on port 1 only after the last beat of port 0 is accepted.
